// File: rtl/counter_sweep_ctrl_pkg.sv
// sweep_ctrl_pkg: shared encodings for the counter sweep controller.
//   state_t       : controller FSM states
//   DIR_UP/DIR_DN : values driven on the counter's up_dwn_n input
package sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// counter_sweep_ctrl_if: bus between the sweep controller and the up/down counter.
//   cnt_rst_n    : counter reset (active low), controller -> counter
//   cnt_act      : counter enable, controller -> counter
//   cnt_up_dwn_n : counter direction, 1 = up, controller -> counter
//   cnt_count    : counter value, counter -> controller
//   cnt_ovflw    : counter overflow, counter -> controller
// master = controller side, slave = counter side.
interface counter_sweep_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             cnt_rst_n;
    logic             cnt_act;
    logic             cnt_up_dwn_n;
    logic [WIDTH-1:0] cnt_count;
    logic             cnt_ovflw;

    modport master (
        output cnt_rst_n, cnt_act, cnt_up_dwn_n,
        input  cnt_count, cnt_ovflw
    );

    modport slave (
        input  cnt_rst_n, cnt_act, cnt_up_dwn_n,
        output cnt_count, cnt_ovflw
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an up/down counter through a programmable number
// of triangle sweeps (0 -> limit -> 0), supervises its overflow and reports
// progress/completion/errors to a host.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : pulse, begins a run (accepted in IDLE only)
//   abort       : pulse, stops any run (priority over everything else)
//   limit       : peak count, sampled on accepted start
//   sweeps      : number of sweeps, sampled on accepted start
//   cnt         : counter bus (master modport)
//   busy        : high in CLR/UP/DOWN
//   done        : one-cycle pulse on normal completion
//   err         : sticky error, cleared by accepted start or reset
//   sweep_done  : sweeps completed in the current run
//
// Build option SWEEP_CTRL_CONTINUOUS_EN: sweeps==0 on start runs forever
// (sweep_done wraps, run ends only by abort or overflow error).
module counter_sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int SWEEP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    limit,
    input  logic [SWEEP_W-1:0]  sweeps,
    counter_sweep_ctrl_if.master cnt,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SWEEP_W-1:0]  sweep_done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lim_q, lim_d;
    logic [SWEEP_W-1:0] swp_q, swp_d;
    logic [SWEEP_W-1:0] sd_d, sd_inc;
    logic               rst_d, act_d, dir_d;
    logic               busy_d, done_d, err_d;
    logic               start_ok, last_sweep;
    logic [WIDTH-1:0]   lim_m1;

    // Counter reaches lim_q on the edge that samples lim_q-1, so the
    // turn-around is decided one count early.
    assign lim_m1 = lim_q - ONE;
    assign sd_inc = sweep_done + 1'b1;

`ifdef SWEEP_CTRL_CONTINUOUS_EN
    assign start_ok   = (limit != '0);
    // swp_q==0 means endless; sweep_done then wraps freely.
    assign last_sweep = (swp_q != '0) && (sd_inc == swp_q);
`else
    assign start_ok   = (limit != '0) && (sweeps != '0);
    assign last_sweep = (sd_inc == swp_q);
`endif

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        swp_d   = swp_q;
        sd_d    = sweep_done;
        rst_d   = 1'b1;         // counter reset released except during CLR
        act_d   = cnt.cnt_act;
        dir_d   = cnt.cnt_up_dwn_n;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;

        if (abort) begin
            // In IDLE abort does nothing, but still blocks a same-cycle start.
            if (state_q != IDLE) begin
                state_d = IDLE;
                act_d   = 1'b0;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            lim_d   = limit;
                            swp_d   = sweeps;
                            err_d   = 1'b0;
                            sd_d    = '0;
                            rst_d   = 1'b0;
                            act_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = CLR;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CLR: begin
                    act_d   = 1'b1;
                    dir_d   = DIR_UP;
                    state_d = UP;
                end
                UP, DOWN: begin
                    if (cnt.cnt_ovflw) begin
                        err_d   = 1'b1;
                        act_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (state_q == UP) begin
                        if (cnt.cnt_count == lim_m1) begin
                            dir_d   = DIR_DN;
                            state_d = DOWN;
                        end
                    end else if (cnt.cnt_count == ONE) begin
                        sd_d  = sd_inc;
                        dir_d = DIR_UP;
                        if (last_sweep) begin
                            act_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = UP;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    act_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            lim_q            <= '0;
            swp_q            <= '0;
            sweep_done       <= '0;
            cnt.cnt_rst_n    <= 1'b0;
            cnt.cnt_act      <= 1'b0;
            cnt.cnt_up_dwn_n <= DIR_UP;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state_q          <= state_d;
            lim_q            <= lim_d;
            swp_q            <= swp_d;
            sweep_done       <= sd_d;
            cnt.cnt_rst_n    <= rst_d;
            cnt.cnt_act      <= act_d;
            cnt.cnt_up_dwn_n <= dir_d;
            busy             <= busy_d;
            done             <= done_d;
            err              <= err_d;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl with a behavioural up/down counter.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] limit = '0;
    logic [3:0] sweeps = '0;
    logic       busy, done, err;
    logic [3:0] sweep_done;
    logic [4:0] cnt = '0;
    logic       force_ovf = 1'b0;
    int         checks = 0;
    int         errors = 0;

    int seq [17] = '{0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0};

    typedef struct {
        logic [4:0] limit;
        logic [3:0] sweeps;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;
    vec_t vecs [6];

    counter_sweep_ctrl_if #(.WIDTH(5)) bus ();

    counter_sweep_ctrl #(.WIDTH(5), .SWEEP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .limit      (limit),
        .sweeps     (sweeps),
        .cnt        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Up/down counter model on the other end of the bus.
    always_ff @(posedge clk or negedge bus.cnt_rst_n) begin
        if (!bus.cnt_rst_n)   cnt <= '0;
        else if (bus.cnt_act) cnt <= bus.cnt_up_dwn_n ? cnt + 5'd1 : cnt - 5'd1;
    end
    assign bus.cnt_count = cnt;
    assign bus.cnt_ovflw = force_ovf | (bus.cnt_act & bus.cnt_up_dwn_n & (cnt == 5'd31));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input logic [4:0] l, input logic [3:0] s);
        start = 1'b1; limit = l; sweeps = s;
        tick();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd3,  4'd1,  1'b0, 1'b1};
        vecs[1] = '{5'd0,  4'd2,  1'b1, 1'b0};
        vecs[2] = '{5'd1,  4'd1,  1'b0, 1'b1};
`ifdef SWEEP_CTRL_CONTINUOUS_EN
        vecs[3] = '{5'd4,  4'd0,  1'b0, 1'b1};
`else
        vecs[3] = '{5'd4,  4'd0,  1'b1, 1'b0};
`endif
        vecs[4] = '{5'd31, 4'd15, 1'b0, 1'b1};
        vecs[5] = '{5'd0,  4'd0,  1'b1, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cnt_rst_n", 32'(bus.cnt_rst_n), 0);
        check("rst_act", 32'(bus.cnt_act), 0);
        check("rst_dir", 32'(bus.cnt_up_dwn_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sd", 32'(sweep_done), 0);
        rst_n = 1'b1;
        #1 check("rel_cnt_rst_n_before_clk", 32'(bus.cnt_rst_n), 0);
        tick();
        check("rel_cnt_rst_n_after_clk", 32'(bus.cnt_rst_n), 1);

        // Normal run: limit=4, sweeps=2
        start_run(5'd4, 4'd2);
        check("clr_busy", 32'(busy), 1);
        check("clr_cnt_rst_n", 32'(bus.cnt_rst_n), 0);
        for (int i = 0; i < 17; i++) begin
            tick();
            check($sformatf("run_count[%0d]", i), 32'(cnt), 32'(seq[i]));
            check($sformatf("run_done[%0d]", i), 32'(done), (i == 16) ? 1 : 0);
            check($sformatf("run_busy[%0d]", i), 32'(busy), (i < 16) ? 1 : 0);
            check($sformatf("run_sd[%0d]", i), 32'(sweep_done), (i < 8) ? 0 : (i < 16) ? 1 : 2);
        end
        tick();
        check("post_done", 32'(done), 0);
        check("post_act", 32'(bus.cnt_act), 0);
        check("post_count", 32'(cnt), 0);
        check("post_sd", 32'(sweep_done), 2);

        // limit=1: UP and DOWN are one cycle each
        start_run(5'd1, 4'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("lim1_count[%0d]", i), 32'(cnt), (i == 4) ? 0 : 32'(i % 2));
            check($sformatf("lim1_done[%0d]", i), 32'(done), (i == 4) ? 1 : 0);
        end
        tick();

        // Abort in DOWN of sweep 1 while count==3
        start_run(5'd4, 4'd2);
        repeat (6) tick();
        check("abt_pre_count", 32'(cnt), 3);
        check("abt_pre_dir", 32'(bus.cnt_up_dwn_n), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_act", 32'(bus.cnt_act), 0);
        check("abt_busy", 32'(busy), 0);
        check("abt_count", 32'(cnt), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abt_frozen", 32'(cnt), 2);
            check("abt_done", 32'(done), 0);
        end
        check("abt_sd", 32'(sweep_done), 0);
        check("abt_err", 32'(err), 0);

        // Start while busy ignored, then forced overflow in UP
        start_run(5'd8, 4'd3);
        repeat (17) tick();
        check("ovf_sd1", 32'(sweep_done), 1);
        check("ovf_count0", 32'(cnt), 0);
        tick();
        start = 1'b1; limit = 5'd5; sweeps = 4'd1;
        tick();
        start = 1'b0;
        check("busy_start_busy", 32'(busy), 1);
        check("busy_start_sd", 32'(sweep_done), 1);
        check("busy_start_count", 32'(cnt), 2);
        force_ovf = 1'b1;
        tick();
        force_ovf = 1'b0;
        check("ovf_err", 32'(err), 1);
        check("ovf_act", 32'(bus.cnt_act), 0);
        check("ovf_busy", 32'(busy), 0);
        check("ovf_done", 32'(done), 0);
        check("ovf_count", 32'(cnt), 3);
        tick();
        check("ovf_count_hold", 32'(cnt), 3);

        // Start acceptance table
        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].limit, vecs[v].sweeps);
            check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            if (vecs[v].exp_busy) begin
                check($sformatf("vec%0d_sd", v), 32'(sweep_done), 0);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check($sformatf("vec%0d_abort_busy", v), 32'(busy), 0);
                check($sformatf("vec%0d_abort_err", v), 32'(err), 0);
            end
        end

`ifdef SWEEP_CTRL_CONTINUOUS_EN
        // Endless run: limit=31, sweeps=0, sweep_done wraps
        start_run(5'd31, 4'd0);
        check("cont_err", 32'(err), 0);
        tick();
        for (int k = 1; k <= 17; k++) begin
            repeat (62) tick();
            check($sformatf("cont_sd[%0d]", k), 32'(sweep_done), 32'(k % 16));
            check($sformatf("cont_count[%0d]", k), 32'(cnt), 0);
            check($sformatf("cont_busy[%0d]", k), 32'(busy), 1);
            check($sformatf("cont_err[%0d]", k), 32'(err), 0);
            check($sformatf("cont_done[%0d]", k), 32'(done), 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("cont_abort_busy", 32'(busy), 0);
        check("cont_abort_act", 32'(bus.cnt_act), 0);
        check("cont_abort_done", 32'(done), 0);
`endif

        // Asynchronous reset mid-run
        start_run(5'd4, 4'd2);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_cnt_rst_n", 32'(bus.cnt_rst_n), 0);
        check("arst_act", 32'(bus.cnt_act), 0);
        check("arst_dir", 32'(bus.cnt_up_dwn_n), 1);
        check("arst_sd", 32'(sweep_done), 0);
        check("arst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_rel_cnt_rst_n", 32'(bus.cnt_rst_n), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the up/down counter (ports act, up_dwn_n, count, ovflw).
- Drives the counter through a programmable number of triangle sweeps: 0 up to LIMIT, then back down to 0.
- Supervises counter overflow and reports progress, completion and errors to a host FSM or CPU register block.
- Instantiated beside the counter; the counter's clk is shared.

Parameters:
- WIDTH, 5, counter and limit width; must match the counter's WIDTH.
- SWEEP_W, 4, width of the sweep-count request and progress fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run (accepted in IDLE only).
- abort  in  1  one-cycle pulse; stops any run.
- limit  in  WIDTH  peak count value; sampled on an accepted start.
- sweeps  in  SWEEP_W  number of sweeps to run; sampled on start.
- cnt_count  in  WIDTH  counter's count output.
- cnt_ovflw  in  1  counter's ovflw output.
- cnt_rst_n  out  1  counter reset, driven from a register.
- cnt_act  out  1  counter enable.
- cnt_up_dwn_n  out  1  counter direction: 1 = up, 0 = down.
- busy  out  1  high in CLR/UP/DOWN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky error flag.
- sweep_done  out  SWEEP_W  sweeps completed in the current run.

Behaviour:
- All outputs are registered. Reset values:
  - cnt_rst_n=0; cnt_act=0; cnt_up_dwn_n=1.
  - busy=0; done=0; err=0; sweep_done=0.
  - state=IDLE; cnt_rst_n goes to 1 on the first clock after reset release.
- States: IDLE, CLR, UP, DOWN, DONE.
- IDLE:
  - start with limit!=0 and sweeps!=0 → latch lim_q and swp_q; clear err and sweep_done; go to CLR.
  - start with limit==0 or sweeps==0 → set err; stay in IDLE.
  - abort in IDLE → no effect.
- CLR (exactly 1 cycle): cnt_rst_n=0, cnt_act=0. Next state UP with cnt_rst_n=1, cnt_act=1, cnt_up_dwn_n=1.
- UP: when cnt_count==lim_q-1 is sampled, the same edge moves the counter to lim_q. Controller then sets cnt_up_dwn_n=0 and goes to DOWN. Peak value is exactly lim_q.
- DOWN: when cnt_count==1 is sampled, the counter reaches 0 on that edge and sweep_done increments.
  - If the new sweep_done==swp_q: cnt_act=0, cnt_up_dwn_n=1, go to DONE.
  - Otherwise: cnt_up_dwn_n=1, go to UP.
- Special case lim_q==1: UP and DOWN each last 1 cycle.
- DONE (1 cycle): done=1, busy=0, then IDLE. The counter holds 0.
- Sweep length: 2*lim_q cycles. A run lasts 1 + 2*lim_q*swp_q cycles from CLR to DONE.
- cnt_ovflw=1 sampled in UP or DOWN → err=1, cnt_act=0, go to IDLE with no done pulse. This cannot happen for lim_q ≤ 2^WIDTH-1; it guards against counter faults.
- abort in CLR/UP/DOWN/DONE → next cycle cnt_act=0 and state IDLE; no done pulse; err unchanged.
- abort has priority over start and over all state transitions in the same cycle.
- start while busy → ignored.
- rst_n asserted mid-run → immediate return to reset values (asynchronous).
- err is cleared only by an accepted start or by reset.
- Arithmetic: the lim_q-1 comparison is WIDTH-bit unsigned. sweep_done is SWEEP_W bits and never wraps, because the run terminates at swp_q.

Optional Feature:
- Macro: SWEEP_CTRL_CONTINUOUS_EN.
- When defined, sweeps==0 on start is legal and means run forever.
  - sweep_done wraps modulo 2^SWEEP_W.
  - The run ends only via abort or overflow error; done is never pulsed.
- When not defined, sweeps==0 is rejected with err=1 as described above.

Decomposition:
- Package sweep_ctrl_pkg holds:
  - state encodings: IDLE=3'd0, CLR=3'd1, UP=3'd2, DOWN=3'd3, DONE=3'd4;
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- No sub-module. FSM, latches and sweep counter live in one module.
- The counter is instantiated alongside at the next level up, not inside this block.

Test Plan:
- Reset → all outputs at reset values; cnt_rst_n returns to 1 one clock after rst_n release.
- Normal run, WIDTH=5, limit=4, sweeps=2:
  - start → cnt_count follows 0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0;
  - sweep_done goes 1 then 2; done pulses once 17 cycles after CLR; busy falls with done.
- limit=0 or sweeps=0 start → err=1, busy stays 0; a next valid start clears err.
- Abort while cnt_count==3 in DOWN of sweep 1 → cnt_act=0 next cycle, count frozen at its value, IDLE, no done.
- Force cnt_ovflw=1 during UP → err=1, cnt_act=0, IDLE; start while busy mid-run is ignored (sweep_done unchanged).
- With SWEEP_CTRL_CONTINUOUS_EN, limit=31, sweeps=0:
  - more than 16 sweeps run, sweep_done wraps 15→0, no ovflw;
  - abort ends the run.
